// File: rtl/pit_stream_rx.sv
// Receiver for the PIT byte stream: frames start_bit-qualified bytes into packets,
// checks the index sequence, tags the last byte and queues bytes for a valid/ready egress.
module pit_stream_rx #(
  parameter int PKT_BYTES  = 1023,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_bit,
  input  logic [7:0] in_data,
  input  logic [9:0] current_byte,
  input  logic       fib_out,
  input  logic       clear_err,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_hit,
  output logic       rx_busy,
  output logic       overflow,
  output logic       seq_err,
  output logic [7:0] pkt_count
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, IGNORE} state_t;

  localparam logic [9:0] CAP = 10'(PKT_BYTES);

  state_t      state_reg, state_next;
  logic [7:0]  hold_reg, hold_next;
  logic        hit_reg, hit_next;
  logic [9:0]  expected_reg, expected_next;
  logic [9:0]  count_reg, count_next;
  logic        push_req, push_last, seq_set, pkt_done;
  logic [9:0]  push_word;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic        full, pop, push_ok;
  logic [9:0]  head_next;

  logic        out_valid_reg, out_last_reg, out_hit_reg;
  logic [7:0]  out_data_reg;
  logic        overflow_reg, seq_err_reg;
  logic [7:0]  pkt_count_reg;

  // The held byte is only pushed once we know whether another byte follows it.
  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    hit_next      = hit_reg;
    expected_next = expected_reg;
    count_next    = count_reg;
    push_req      = 1'b0;
    push_last     = 1'b0;
    seq_set       = 1'b0;
    pkt_done      = 1'b0;
    case (state_reg)
      IDLE, FLUSH: begin
        if (state_reg == FLUSH) begin
          push_req   = 1'b1;
          push_last  = 1'b1;
          pkt_done   = 1'b1;
          state_next = IDLE;
        end
        // A new frame may start in the flush cycle so back-to-back packets are not lost.
        if (start_bit) begin
          hold_next     = in_data;
          hit_next      = fib_out;
          expected_next = 10'd1;
          count_next    = 10'd1;
          seq_set       = (current_byte != 10'd0);
          state_next    = RECV;
        end
      end
      RECV: begin
        if (!start_bit) begin
          state_next = FLUSH;
        end else if (count_reg == CAP) begin
          push_req   = 1'b1;
          push_last  = 1'b1;
          pkt_done   = 1'b1;
          state_next = IGNORE;
        end else begin
          push_req      = 1'b1;
          hold_next     = in_data;
          count_next    = count_reg + 10'd1;
          seq_set       = (current_byte != expected_reg);
          expected_next = expected_reg + 10'd1;
        end
      end
      IGNORE: begin
        if (!start_bit) state_next = IDLE;
      end
      default: state_next = IGNORE;
    endcase
  end

  assign push_word   = {push_last, hit_reg, hold_reg};
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop         = out_valid_reg & out_ready;
  assign push_ok     = push_req & (~full | pop);
  assign wr_ptr_next = wr_ptr_reg + (AW+1)'(push_ok);
  assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);
  // Bypass the array when the new head is the entry being written this cycle.
  assign head_next   = (push_ok && (rd_ptr_next == wr_ptr_reg)) ? push_word
                                                                : mem[rd_ptr_next[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IGNORE;
      hold_reg      <= '0;
      hit_reg       <= 1'b0;
      expected_reg  <= '0;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_hit_reg   <= 1'b0;
      out_data_reg  <= '0;
      overflow_reg  <= 1'b0;
      seq_err_reg   <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hit_reg       <= hit_next;
      expected_reg  <= expected_next;
      count_reg     <= count_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      out_valid_reg <= (wr_ptr_next != rd_ptr_next);
      {out_last_reg, out_hit_reg, out_data_reg} <= head_next;
      // Set has priority over clear.
      overflow_reg  <= (push_req & ~push_ok) | (overflow_reg & ~clear_err);
      seq_err_reg   <= seq_set | (seq_err_reg & ~clear_err);
      if (pkt_done) pkt_count_reg <= pkt_count_reg + 8'd1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_hit   = out_hit_reg;
  assign rx_busy   = (state_reg != IDLE);
  assign overflow  = overflow_reg;
  assign seq_err   = seq_err_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_pit_stream_rx.sv
// Scoreboard bench for pit_stream_rx: stimulus queues expected egress entries,
// a negedge monitor pops and compares every accepted output byte.
module tb_pit_stream_rx;

  localparam int CAP = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_bit;
  logic [7:0] in_data;
  logic [9:0] current_byte;
  logic       fib_out;
  logic       clear_err;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_hit;
  logic       rx_busy;
  logic       overflow;
  logic       seq_err;
  logic [7:0] pkt_count;

  always #5 clk = ~clk;

  pit_stream_rx #(.PKT_BYTES(CAP), .FIFO_DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .start_bit(start_bit), .in_data(in_data),
    .current_byte(current_byte), .fib_out(fib_out), .clear_err(clear_err),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_hit(out_hit), .rx_busy(rx_busy),
    .overflow(overflow), .seq_err(seq_err), .pkt_count(pkt_count)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  // Monitor: every accepted egress byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL egress unexpected: got data=%02h last=%0b hit=%0b, required no output",
                 out_data, out_last, out_hit);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_last, out_hit, out_data} !== mon_exp) begin
          miscompares++;
          $display("FAIL egress: got data=%02h last=%0b hit=%0b, required data=%02h last=%0b hit=%0b",
                   out_data, out_last, out_hit, mon_exp[7:0], mon_exp[9], mon_exp[8]);
        end else begin
          $display("egress data=%02h last=%0b hit=%0b ok", out_data, out_last, out_hit);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [9:0] idx, input logic hit);
    start_bit    = 1'b1;
    in_data      = d;
    current_byte = idx;
    fib_out      = hit;
    tick();
  endtask

  task automatic gap(input int n);
    start_bit = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check({name, " scoreboard empty"}, exp_q.size(), 0);
    check({name, " out_valid idle"}, out_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start_bit = 1'b0; in_data = '0; current_byte = '0;
    fib_out = 1'b0; clear_err = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data", out_data, 8'h00);
    check("rst out_last", out_last, 1'b0);
    check("rst out_hit", out_hit, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst seq_err", seq_err, 1'b0);
    check("rst pkt_count", pkt_count, 8'd0);
    check("rst busy (ignore)", rx_busy, 1'b1);
    reset = 1'b1;
    tick();
    check("idle busy", rx_busy, 1'b0);

    // Single packet A0..A3, hit=1
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 1'b1, 8'(8'hA0 + i)});
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 10'(i), 1'b1);
    gap(4);
    drain("single");
    check("single pkt_count", pkt_count, 8'd1);
    check("single overflow", overflow, 1'b0);
    check("single seq_err", seq_err, 1'b0);

    // Backpressure: 20-byte packet into 16-entry FIFO, last 4 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 1'b0, 8'(8'h30 + i)});
    for (int i = 0; i < 20; i++) send(8'(8'h30 + i), 10'(i), 1'b0);
    gap(3);
    check("ovf out_valid", out_valid, 1'b1);
    check("ovf head", out_data, 8'h30);
    check("ovf flag", overflow, 1'b1);
    check("ovf pkt_count", pkt_count, 8'd2);
    out_ready = 1'b1;
    drain("ovf");
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("ovf cleared", overflow, 1'b0);

    // Sequence error: indices 0,1,3
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b0, 8'h22});
    exp_q.push_back({1'b1, 1'b0, 8'h33});
    send(8'h11, 10'd0, 1'b0);
    send(8'h22, 10'd1, 1'b0);
    check("seq before gap", seq_err, 1'b0);
    send(8'h33, 10'd3, 1'b0);
    check("seq after gap", seq_err, 1'b1);
    gap(4);
    drain("seq");
    check("seq pkt_count", pkt_count, 8'd3);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("seq cleared", seq_err, 1'b0);

    // Length cap: CAP+3 bytes with start_bit held, then a fresh frame
    for (int i = 0; i < CAP; i++) exp_q.push_back({(i == CAP - 1), 1'b1, 8'(128 + i)});
    exp_q.push_back({1'b1, 1'b0, 8'h77});
    for (int i = 0; i < CAP + 3; i++) send(8'(128 + i), 10'(i), 1'b1);
    check("cap busy in ignore", rx_busy, 1'b1);
    check("cap pkt_count", pkt_count, 8'd4);
    gap(1);
    send(8'h77, 10'd0, 1'b0);
    gap(4);
    drain("cap");
    check("cap seq_err", seq_err, 1'b0);
    check("cap next pkt_count", pkt_count, 8'd5);

    // Reset mid-packet with start_bit held high
    out_ready = 1'b0;
    send(8'h61, 10'd0, 1'b0);
    send(8'h62, 10'd1, 1'b0);
    reset = 1'b0;
    send(8'h63, 10'd2, 1'b0);
    reset = 1'b1;
    for (int i = 3; i < 6; i++) send(8'(8'h61 + i), 10'(i), 1'b0);
    check("mid rst out_valid", out_valid, 1'b0);
    check("mid rst pkt_count", pkt_count, 8'd0);
    check("mid rst busy", rx_busy, 1'b1);
    out_ready = 1'b1;
    gap(4);
    check("mid rst nothing captured", out_valid, 1'b0);
    check("mid rst idle", rx_busy, 1'b0);

    // Back-to-back single-byte packets
    exp_q.push_back({1'b1, 1'b0, 8'h5A});
    exp_q.push_back({1'b1, 1'b1, 8'h5B});
    send(8'h5A, 10'd0, 1'b0);
    gap(1);
    send(8'h5B, 10'd0, 1'b1);
    gap(4);
    drain("b2b");
    check("b2b pkt_count", pkt_count, 8'd2);
    check("b2b seq_err", seq_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
